thermal_governor: RTL and testbench

- Closed-loop controller on the opposite side of the BM1387 thermal/power model.
- Consumes the model's temperature, power_consumption and throttle_request. Drives the model's hash-rate and power-request inputs plus a fan PWM.
- Ramps hash rate toward a ceiling, holds at a target temperature with hysteresis, backs off on overheat or throttle, and latches a fault shutdown on sustained critical temperature.

---
 rtl/thermal_governor.sv | 204 ++++++++++++++++++++
 tb/tb_thermal_governor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_governor.sv
// thermal_governor: closed-loop hash-rate / fan controller for the BM1387 thermal model.
// Ramps the commanded hash rate toward a ceiling, holds around a target temperature
// with hysteresis, backs off on overheat or throttle, and latches a fault shutdown
// after sustained critical temperature. Decisions are made once per SAMPLE_DIV clocks.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              run request from firmware
//   temperature         die temperature (degC)
//   throttle_request    throttle flag from thermal model
//   power_consumption   measured power (mW), registered to power_observed at each tick
//   hash_target_max     hash-rate ceiling
//   hashes_per_second   commanded hash rate
//   power_request       commanded power (mW)
//   power_observed      power_consumption captured at the last tick
//   fan_duty, fan_pwm   fan duty cycle and its PWM waveform
//   gov_state           FSM state (OFF=0 RAMP=1 HOLD=2 BACKOFF=3 SHUTDOWN=4)
//   fault               shutdown latched
module thermal_governor #(
  parameter int unsigned SAMPLE_DIV       = 256,
  parameter int unsigned T_TARGET         = 85,
  parameter int unsigned T_HYST           = 5,
  parameter int unsigned T_SHUTDOWN       = 120,
  parameter int unsigned SHUTDOWN_SAMPLES = 4,
  parameter logic [15:0] HASH_STEP        = 16'h0100,
  parameter logic [15:0] POWER_IDLE       = 16'h0258,
  parameter logic [7:0]  FAN_MIN          = 8'h40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  temperature,
  input  logic        throttle_request,
  input  logic [15:0] power_consumption,
  input  logic [15:0] hash_target_max,
  output logic [15:0] hashes_per_second,
  output logic [15:0] power_request,
  output logic [15:0] power_observed,
  output logic [7:0]  fan_duty,
  output logic        fan_pwm,
  output logic [2:0]  gov_state,
  output logic        fault
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned ScW  = $clog2(SHUTDOWN_SAMPLES + 1);

  localparam logic [8:0] HotThr  = 9'(T_TARGET + T_HYST);
  localparam logic [8:0] CoolThr = 9'(T_TARGET - T_HYST);
  localparam logic [8:0] TgtThr  = 9'(T_TARGET);
  localparam logic [8:0] CritThr = 9'(T_SHUTDOWN);
  localparam logic [8:0] FanBase = 9'(T_TARGET - 20);

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StRamp     = 3'd1,
    StHold     = 3'd2,
    StBackoff  = 3'd3,
    StShutdown = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q;
  logic [ScW-1:0]  scnt_q, scnt_d;
  logic [15:0]     hash_q, hash_d;
  logic [15:0]     power_q, power_d;
  logic [15:0]     pobs_q, pobs_d;
  logic [7:0]      duty_q, duty_d;
  logic [7:0]      pwm_cnt_q;
  logic            pwm_q;
  logic            fault_q, fault_d;

  logic            tick;
  logic            temp_hot, temp_cool, temp_le_tgt, temp_ge_tgt, temp_crit, backoff_cause;
  logic [16:0]     ramp_sum, back_diff, power_sum;
  logic [15:0]     ramp_next, back_next, hold_hash;
  logic [ScW-1:0]  scnt_inc;
  logic [11:0]     temp_off, duty_raw;
  logic [7:0]      duty_calc;

  assign tick = (div_q == DivW'(SAMPLE_DIV - 1));

  assign temp_hot      = {1'b0, temperature} >  HotThr;
  assign temp_cool     = {1'b0, temperature} <  CoolThr;
  assign temp_le_tgt   = {1'b0, temperature} <= TgtThr;
  assign temp_ge_tgt   = {1'b0, temperature} >= TgtThr;
  assign temp_crit     = {1'b0, temperature} >= CritThr;
  assign backoff_cause = throttle_request | temp_hot;

  // Ramp saturates at the ceiling; backoff clamps at zero instead of wrapping.
  assign ramp_sum  = {1'b0, hash_q} + {1'b0, HASH_STEP};
  assign ramp_next = (ramp_sum > {1'b0, hash_target_max}) ? hash_target_max : ramp_sum[15:0];
  assign back_diff = {1'b0, hash_q} - {HASH_STEP, 1'b0};
  assign back_next = ({1'b0, hash_q} >= {HASH_STEP, 1'b0}) ? back_diff[15:0] : 16'h0000;
  assign hold_hash = (hash_q > hash_target_max) ? hash_target_max : hash_q;

  assign scnt_inc = (scnt_q == ScW'(SHUTDOWN_SAMPLES)) ? scnt_q : scnt_q + 1'b1;

  assign temp_off  = 12'(temperature) - 12'(FanBase);
  assign duty_raw  = 12'(FAN_MIN) + (temp_off << 3);
  assign duty_calc = ({1'b0, temperature} <= FanBase) ? FAN_MIN :
                     (duty_raw > 12'h0FF) ? 8'hFF : duty_raw[7:0];

  assign power_sum = {1'b0, POWER_IDLE} + {3'b000, hash_d[15:2]};
  assign power_d   = power_sum[16] ? 16'hFFFF : power_sum[15:0];

  always_comb begin
    state_d = state_q;
    hash_d  = hash_q;
    fault_d = fault_q;
    scnt_d  = scnt_q;
    duty_d  = duty_q;
    pobs_d  = pobs_q;
    if (tick) begin
      pobs_d = power_consumption;
      if (state_q == StOff || !temp_crit) scnt_d = '0;
      else                                scnt_d = scnt_inc;

      if (state_q != StOff && scnt_d == ScW'(SHUTDOWN_SAMPLES)) begin
        state_d = StShutdown;
        hash_d  = '0;
        fault_d = 1'b1;
      end else if (!enable) begin
        if (state_q == StShutdown) begin
          if (temp_cool) begin
            state_d = StOff;
            fault_d = 1'b0;
            scnt_d  = '0;
          end
        end else begin
          state_d = StOff;
          hash_d  = '0;
        end
      end else begin
        unique case (state_q)
          StOff: state_d = StRamp;
          StRamp: begin
            if (backoff_cause)    state_d = StBackoff;
            else if (temp_ge_tgt) state_d = StHold;
            else begin
              hash_d = ramp_next;
              if (ramp_next == hash_target_max) state_d = StHold;
            end
          end
          StHold: begin
            hash_d = hold_hash;
            if (backoff_cause)                                state_d = StBackoff;
            else if (temp_cool && hash_q < hash_target_max) state_d = StRamp;
          end
          StBackoff: begin
            // Recovery tick keeps the hash where it is.
            if (temp_le_tgt && !throttle_request) state_d = StHold;
            else                                  hash_d  = back_next;
          end
          StShutdown: hash_d = '0;
          default: begin
            state_d = StOff;
            hash_d  = '0;
          end
        endcase
      end
      duty_d = (state_d == StShutdown) ? 8'hFF : duty_calc;
    end else if (!enable && state_q != StShutdown) begin
      // Firmware disable takes effect immediately, not at the next tick.
      state_d = StOff;
      hash_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      state_q   <= StOff;
      scnt_q    <= '0;
      hash_q    <= '0;
      power_q   <= POWER_IDLE;
      pobs_q    <= '0;
      duty_q    <= FAN_MIN;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      div_q     <= tick ? '0 : div_q + 1'b1;
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      hash_q    <= hash_d;
      power_q   <= power_d;
      pobs_q    <= pobs_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= (pwm_cnt_q < duty_q);
      fault_q   <= fault_d;
    end
  end

  assign hashes_per_second = hash_q;
  assign power_request     = power_q;
  assign power_observed    = pobs_q;
  assign fan_duty          = duty_q;
  assign fan_pwm           = pwm_q;
  assign gov_state         = state_q;
  assign fault             = fault_q;

endmodule

// File: tb/tb_thermal_governor.sv
// Bench for thermal_governor with SAMPLE_DIV=4: directed scenarios with literal
// expectations, then randomized stimulus, all outputs compared each cycle against a
// tick-level behavioural model.
module tb_thermal_governor;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  temperature;
  logic        throttle_request;
  logic [15:0] power_consumption;
  logic [15:0] hash_target_max;
  logic [15:0] hashes_per_second;
  logic [15:0] power_request;
  logic [15:0] power_observed;
  logic [7:0]  fan_duty;
  logic        fan_pwm;
  logic [2:0]  gov_state;
  logic        fault;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  thermal_governor #(.SAMPLE_DIV(SD)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .temperature       (temperature),
    .throttle_request  (throttle_request),
    .power_consumption (power_consumption),
    .hash_target_max   (hash_target_max),
    .hashes_per_second (hashes_per_second),
    .power_request     (power_request),
    .power_observed    (power_observed),
    .fan_duty          (fan_duty),
    .fan_pwm           (fan_pwm),
    .gov_state         (gov_state),
    .fault             (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0..4 as in gov_state, plain integer arithmetic per tick.
  int m_div, m_st, m_hash, m_fault, m_scnt, m_duty, m_pobs, m_preq, m_pcnt, m_pwm;
  int t, next_pwm;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_div = 0; m_st = 0; m_hash = 0; m_fault = 0; m_scnt = 0;
      m_duty = 64; m_pobs = 0; m_preq = 600; m_pcnt = 0; m_pwm = 0;
    end else begin
      t = int'(temperature);
      next_pwm = (m_pcnt < m_duty) ? 1 : 0;
      m_pcnt = (m_pcnt + 1) % 256;
      if (m_div == SD - 1) begin
        m_div = 0;
        m_pobs = int'(power_consumption);
        if (m_st == 0 || t < 120) m_scnt = 0;
        else if (m_scnt < 4) m_scnt = m_scnt + 1;
        if (m_st != 0 && m_scnt == 4) begin
          m_st = 4; m_hash = 0; m_fault = 1;
        end else if (!enable) begin
          if (m_st == 4) begin
            if (t < 80) begin m_st = 0; m_fault = 0; m_scnt = 0; end
          end else begin
            m_st = 0; m_hash = 0;
          end
        end else if (m_st == 0) begin
          m_st = 1;
        end else if (m_st == 1) begin
          if (throttle_request || t > 90) m_st = 3;
          else if (t >= 85) m_st = 2;
          else begin
            m_hash = (m_hash + 256 > int'(hash_target_max)) ? int'(hash_target_max) : m_hash + 256;
            if (m_hash == int'(hash_target_max)) m_st = 2;
          end
        end else if (m_st == 2) begin
          if (throttle_request || t > 90) m_st = 3;
          else if (t < 80 && m_hash < int'(hash_target_max)) m_st = 1;
          if (m_hash > int'(hash_target_max)) m_hash = int'(hash_target_max);
        end else if (m_st == 3) begin
          if (t <= 85 && !throttle_request) m_st = 2;
          else m_hash = (m_hash >= 512) ? m_hash - 512 : 0;
        end else begin
          m_hash = 0;
        end
        if (m_st == 4) m_duty = 255;
        else if (t <= 65) m_duty = 64;
        else m_duty = (64 + (t - 65) * 8 > 255) ? 255 : 64 + (t - 65) * 8;
      end else begin
        m_div = m_div + 1;
        if (!enable && m_st != 4) begin m_st = 0; m_hash = 0; end
      end
      m_preq = (600 + m_hash / 4 > 65535) ? 65535 : 600 + m_hash / 4;
      m_pwm = next_pwm;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hash",     32'(hashes_per_second), 32'(m_hash));
      check("power_req", 32'(power_request),    32'(m_preq));
      check("power_obs", 32'(power_observed),   32'(m_pobs));
      check("fan_duty", 32'(fan_duty),          32'(m_duty));
      check("fan_pwm",  32'(fan_pwm),           32'(m_pwm));
      check("state",    32'(gov_state),         32'(m_st));
      check("fault",    32'(fault),             32'(m_fault));
    end
  end

  task automatic drive(input logic en, input logic [7:0] tp, input logic thr);
    #1;
    enable = en;
    temperature = tp;
    throttle_request = thr;
  endtask

  task automatic win(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  int pwm_high;
  int r;

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    temperature = 8'd25;
    throttle_request = 1'b0;
    power_consumption = 16'd1234;
    hash_target_max = 16'h0400;
    chk_en = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_hash",  32'(hashes_per_second), 32'h0);
    check("rst_preq",  32'(power_request),     32'h0258);
    check("rst_duty",  32'(fan_duty),          32'h40);
    check("rst_state", 32'(gov_state),         32'd0);
    check("rst_fault", 32'(fault),             32'd0);
    check("rst_pwm",   32'(fan_pwm),           32'd0);

    #1 reset_n = 1'b1;
    enable = 1'b1;
    temperature = 8'd60;

    // Ramp to the ceiling.
    win(1);
    check("ramp_enter", 32'(gov_state), 32'd1);
    check("ramp_h0", 32'(hashes_per_second), 32'h0);
    win(4);
    check("ramp_top", 32'(hashes_per_second), 32'h0400);
    check("ramp_hold", 32'(gov_state), 32'd2);
    check("ramp_preq", 32'(power_request), 32'h0358);

    // Overheat backoff and recovery.
    drive(1'b1, 8'd91, 1'b0);
    win(1);
    check("bo_enter", 32'(gov_state), 32'd3);
    check("bo_h0", 32'(hashes_per_second), 32'h0400);
    win(1);
    check("bo_h1", 32'(hashes_per_second), 32'h0200);
    win(1);
    check("bo_h2", 32'(hashes_per_second), 32'h0000);
    drive(1'b1, 8'd85, 1'b0);
    win(1);
    check("bo_recover", 32'(gov_state), 32'd2);
    check("bo_rec_hash", 32'(hashes_per_second), 32'h0000);
    drive(1'b1, 8'd79, 1'b0);
    win(1);
    check("hold_to_ramp", 32'(gov_state), 32'd1);

    // Throttle backoff with zero floor.
    drive(1'b1, 8'd60, 1'b0);
    win(4);
    check("reramp", 32'(hashes_per_second), 32'h0400);
    drive(1'b1, 8'd70, 1'b1);
    win(1);
    check("thr_enter", 32'(gov_state), 32'd3);
    win(2);
    check("thr_zero", 32'(hashes_per_second), 32'h0);
    win(1);
    check("thr_floor", 32'(hashes_per_second), 32'h0);

    // Shutdown needs four consecutive critical ticks.
    drive(1'b1, 8'd120, 1'b0);
    win(3);
    drive(1'b1, 8'd119, 1'b0);
    win(1);
    drive(1'b1, 8'd120, 1'b0);
    win(3);
    check("sd_not_yet", 32'(gov_state), 32'd3);
    win(1);
    check("sd_state", 32'(gov_state), 32'd4);
    check("sd_fault", 32'(fault), 32'd1);
    check("sd_duty", 32'(fan_duty), 32'hFF);
    check("sd_hash", 32'(hashes_per_second), 32'h0);
    drive(1'b0, 8'd100, 1'b0);
    win(1);
    check("sd_stay", 32'(gov_state), 32'd4);
    drive(1'b0, 8'd79, 1'b0);
    win(1);
    check("sd_exit", 32'(gov_state), 32'd0);
    check("sd_fault_clr", 32'(fault), 32'd0);

    // Fan curve.
    drive(1'b0, 8'd65, 1'b0);
    win(1);
    check("fan_65", 32'(fan_duty), 32'h40);
    drive(1'b0, 8'd75, 1'b0);
    win(1);
    check("fan_75", 32'(fan_duty), 32'h90);
    pwm_high = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pwm_high += int'(fan_pwm);
    end
    check("pwm_high", 32'(pwm_high), 32'd144);
    drive(1'b0, 8'd110, 1'b0);
    win(1);
    check("fan_110", 32'(fan_duty), 32'hFF);

    // Disable mid-ramp acts on the next clock.
    drive(1'b1, 8'd60, 1'b0);
    win(3);
    check("pre_dis_hash", 32'(hashes_per_second), 32'h0200);
    drive(1'b0, 8'd60, 1'b0);
    @(negedge clk);
    check("dis_state", 32'(gov_state), 32'd0);
    check("dis_hash", 32'(hashes_per_second), 32'h0);

    // Randomized run.
    enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      power_consumption = 16'($urandom);
      r = int'($urandom_range(0, 999));
      if (r < 60) begin
        if ($urandom_range(0, 3) == 0) temperature = 8'($urandom_range(118, 125));
        else temperature = 8'($urandom_range(55, 100));
      end
      if (r >= 100 && r < 115) throttle_request = ~throttle_request;
      if (r >= 200 && r < 205) enable = 1'b0;
      if (r >= 300 && r < 330) enable = 1'b1;
      if (r >= 400 && r < 410) hash_target_max = 16'($urandom_range(0, 16'h0A00));
      if (r >= 500 && r < 503) hash_target_max = 16'hFFFF;
      reset_n = (r == 999) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
